comparator_offset_cal: RTL and testbench
========================================

# comparator_offset_cal

Digital offset-calibration controller that sits directly around the continuous-time comparator: it consumes the comparator's `out` and produces its `cfg_offset_p[4:0]` / `cfg_offset_n[4:0]` trim codes. On `start` it asserts `cal_en`, which shorts the comparator inputs externally. It then runs a sign decision followed by a 5-bit successive-approximation search on one trim side, and holds the resulting code until the next calibration.

## Interface
- `SETTLE_CYCLES`, default 16: clock cycles allowed for the comparator to settle after each code change. Legal range 1..255.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  single-cycle request to begin calibration. Honoured only in IDLE or DONE.
- `comp_out`  input  1  comparator `out`; asynchronous to `clk`.
- `cfg_offset_p`  output  5  positive-side trim code, in 1 mV/LSB.
- `cfg_offset_n`  output  5  negative-side trim code, in 1 mV/LSB.
- `cal_en`  output  1  shorts the comparator inputs; high while busy.
- `busy`  output  1  calibration in progress.
- `done`  output  1  one-cycle pulse when the result is final.
- `cal_sat`  output  1  result magnitude is 31 and the comparator never flipped; held with the result.

## Operation
- `comp_out` passes through a 2-flop synchronizer. All decisions use the synchronized value `cs`.
- States:
  - IDLE: outputs at their reset values.
  - SETTLE: code applied, settle counter running.
  - SAMPLE: capture `cs`.
  - DECIDE: update the code.
  - DONE: result held.
- Sign step:
  - Apply p=0, n=0 and settle.
  - `cs=0` selects side P, which adds positive trim.
  - `cs=1` selects side N.
- Magnitude SAR: for bit b = 4 down to 0:
  - Set bit b on the selected side, then settle and sample.
  - Side P: clear the bit if `cs=1`.
  - Side N: clear the bit if `cs=0`.
  - The result is the largest magnitude that does not flip the comparator from its sign-step value.
- The code on the unselected side stays 0 throughout the SAR.
- `cal_sat` = selected magnitude is 31 after the bit-0 decision.
- `start` while `busy` is ignored.
- `start` in DONE begins a new calibration; the codes reset to 0 at the start of the sign step.
- Reset mid-calibration: on `rst`, all outputs clear immediately to 0 and the state returns to IDLE.
- Reset values: `cfg_offset_p`=0, `cfg_offset_n`=0, `cal_en`=0, `busy`=0, `done`=0, `cal_sat`=0.

## Timing
- Cycle 0: `start` is sampled high in IDLE or DONE.
- Cycle 1:
  - `busy`=1, `cal_en`=1, codes=0.
  - Enter SETTLE with the counter loaded to SETTLE_CYCLES.
- Each decision takes SETTLE_CYCLES cycles in SETTLE, 1 in SAMPLE and 1 in DECIDE.
- A new code appears on the outputs in the cycle SETTLE is entered.
- There are 6 decisions: 1 sign step and 5 SAR bits.
- `done` pulses on cycle 6·(SETTLE_CYCLES+2)+1; at the same time `busy` and `cal_en` fall.
- Synchronizer latency (2 cycles) is covered by SETTLE_CYCLES ≥ 1 plus the comparator's own settling. No extra wait is inserted.

## Configuration
- `COMP_CAL_VOTE_EN` defined:
  - SAMPLE lasts 3 cycles, capturing `cs` on each.
  - The decision uses the 2-of-3 majority.
  - Decision length becomes SETTLE_CYCLES+4 cycles; `done` pulses on cycle 6·(SETTLE_CYCLES+4)+1.
- `COMP_CAL_VOTE_EN` undefined: single-sample decision as described under Operation.

## Structure
- Shared package `comparator_cal_pkg` contains:
  - the state enum `cal_state_t` (IDLE, SETTLE, SAMPLE, DECIDE, DONE);
  - the side enum `cal_side_t` (SIDE_P, SIDE_N);
  - `CAL_CODE_W` = 5.
- One sub-module, `comp_out_sync`: the 2-flop synchronizer for `comp_out`.
- The FSM, settle counter, bit index and vote logic stay in the top module.

## Test plan
- Bench comparator model: `comp_out` = 1 iff (p − n) mV + Vos ≥ 0, with the model's own settling delay of 2 cycles. SETTLE_CYCLES = 4 throughout.
- Vos = −7.4 mV, pulse `start`:
  - side P selected.
  - `done` pulses at cycle 37.
  - Result p=7, n=0, `cal_sat`=0.
- Vos = +12.6 mV:
  - side N selected.
  - Result n=12, p=0, `cal_sat`=0.
- Vos = 0.0 mV:
  - sign step gives `cs`=1, so side N is selected.
  - Result n=0, p=0, `cal_sat`=0.
- Vos = −40 mV:
  - Result p=31, n=0.
  - `cal_sat`=1 and stays held through DONE until the next `start`.
- Reset mid-run and `start` while busy:
  - Assert `rst` during the bit-2 SETTLE: all outputs are 0 immediately, state is IDLE.
  - A second `start` pulse while `busy` has no effect on timing or result.
- With `COMP_CAL_VOTE_EN` defined, Vos = −7.4 mV and one forced `comp_out` glitch in one of the three samples:
  - Result is still p=7.
  - `done` pulses at cycle 49.

Source files
------------

// File: rtl/comparator_cal_pkg.sv
// Shared types and widths for the comparator offset-calibration controller.
package comparator_cal_pkg;
    localparam int CAL_CODE_W = 5;
    localparam logic [CAL_CODE_W-1:0] CAL_CODE_MAX = '1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE} cal_state_t;
    typedef enum logic {SIDE_P, SIDE_N} cal_side_t;
endpackage

// File: rtl/comp_out_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into clk.
module comp_out_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/comparator_offset_cal.sv
// Comparator offset calibration: sign decision then 5-bit SAR on one trim side.
// Define COMP_CAL_VOTE_EN for 3-sample majority voting in SAMPLE.
module comparator_offset_cal
    import comparator_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  comp_out,
    output logic [CAL_CODE_W-1:0] cfg_offset_p,
    output logic [CAL_CODE_W-1:0] cfg_offset_n,
    output logic                  cal_en,
    output logic                  busy,
    output logic                  done,
    output logic                  cal_sat
);
`ifdef COMP_CAL_VOTE_EN
    localparam int NSAMP = 3;
`else
    localparam int NSAMP = 1;
`endif
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [2:0] TOP_BIT     = 3'(CAL_CODE_W - 1);

    cal_state_t            state_q, state_d;
    cal_side_t             side_q, side_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic                  sign_q, sign_d;
    logic [CAL_CODE_W-1:0] code_p_q, code_p_d;
    logic [CAL_CODE_W-1:0] code_n_q, code_n_d;
    logic [NSAMP-1:0]      samp_q, samp_d;
    logic                  done_q, done_d;
    logic                  sat_q, sat_d;
    logic                  cs, decision, keep;
    logic [CAL_CODE_W-1:0] mag;
`ifdef COMP_CAL_VOTE_EN
    logic [1:0]            scnt_q, scnt_d;
`endif

    comp_out_sync u_sync (.clk(clk), .rst(rst), .d(comp_out), .q(cs));

`ifdef COMP_CAL_VOTE_EN
    assign decision = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
`else
    assign decision = samp_q[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            side_q   <= SIDE_P;
            cnt_q    <= '0;
            bit_q    <= '0;
            sign_q   <= 1'b0;
            code_p_q <= '0;
            code_n_q <= '0;
            samp_q   <= '0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
`ifdef COMP_CAL_VOTE_EN
            scnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            side_q   <= side_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sign_q   <= sign_d;
            code_p_q <= code_p_d;
            code_n_q <= code_n_d;
            samp_q   <= samp_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
`ifdef COMP_CAL_VOTE_EN
            scnt_q   <= scnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sign_d   = sign_q;
        code_p_d = code_p_q;
        code_n_d = code_n_q;
        samp_d   = samp_q;
        done_d   = 1'b0;
        sat_d    = sat_q;
        keep     = 1'b0;
        mag      = '0;
`ifdef COMP_CAL_VOTE_EN
        scnt_d   = scnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SETTLE;
                    cnt_d    = SETTLE_LOAD;
                    code_p_d = '0;
                    code_n_d = '0;
                    sat_d    = 1'b0;
                    sign_d   = 1'b1;
                    side_d   = SIDE_P;
                    bit_d    = TOP_BIT;
                end
            end
            SETTLE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = SAMPLE;
`ifdef COMP_CAL_VOTE_EN
                    scnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
`ifdef COMP_CAL_VOTE_EN
                samp_d = {samp_q[1:0], cs};
                if (scnt_q == 2'd2) state_d = DECIDE;
                else                scnt_d  = scnt_q + 2'd1;
`else
                samp_d  = cs;
                state_d = DECIDE;
`endif
            end
            DECIDE: begin
                if (sign_q) begin
                    // cs=0 means the comparator needs positive trim
                    side_d          = decision ? SIDE_N : SIDE_P;
                    sign_d          = 1'b0;
                    bit_d           = TOP_BIT;
                    mag             = '0;
                    mag[TOP_BIT]    = 1'b1;
                    state_d         = SETTLE;
                    cnt_d           = SETTLE_LOAD;
                    if (decision) code_n_d = mag;
                    else          code_p_d = mag;
                end else begin
                    keep = (side_q == SIDE_P) ? ~decision : decision;
                    mag  = (side_q == SIDE_P) ? code_p_q : code_n_q;
                    if (!keep) mag[bit_q] = 1'b0;
                    if (bit_q == 3'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        sat_d   = (mag == CAL_CODE_MAX);
                    end else begin
                        bit_d      = bit_q - 3'd1;
                        mag[bit_d] = 1'b1;
                        state_d    = SETTLE;
                        cnt_d      = SETTLE_LOAD;
                    end
                    if (side_q == SIDE_P) code_p_d = mag;
                    else                  code_n_d = mag;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == DECIDE);
        cal_en       = busy;
        done         = done_q;
        cal_sat      = sat_q;
        cfg_offset_p = code_p_q;
        cfg_offset_n = code_n_q;
    end
endmodule

// File: tb/tb_comparator_offset_cal.sv
// Directed bench: behavioural comparator (offset in 0.1 mV, 2-cycle settle) around the calibrator.
module tb_comparator_offset_cal;
`ifdef COMP_CAL_VOTE_EN
    localparam int DEC_LEN = 8;
`else
    localparam int DEC_LEN = 6;
`endif
    localparam int DONE_CYC = 6 * DEC_LEN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       comp_out;
    logic [4:0] cfg_offset_p, cfg_offset_n;
    logic       cal_en, busy, done, cal_sat;

    int   vos_t = 0;
    logic m1 = 1'b0, m2 = 1'b0, glitch = 1'b0;
    int   errors = 0, checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m1 <= (((int'(cfg_offset_p) - int'(cfg_offset_n)) * 10 + vos_t) >= 0);
        m2 <= m1;
    end
    assign comp_out = m2 ^ glitch;

    comparator_offset_cal #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .comp_out(comp_out),
        .cfg_offset_p(cfg_offset_p), .cfg_offset_n(cfg_offset_n),
        .cal_en(cal_en), .busy(busy), .done(done), .cal_sat(cal_sat)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic run_cal(input string tag, input int vos, input bit side_n,
                           input int exp_p, input int exp_n, input int exp_sat,
                           input int extra_start, input int glitch_cyc);
        int n;
        vos_t = vos;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        chk({tag, ":busy@1"}, busy, 1);
        chk({tag, ":cal_en@1"}, cal_en, 1);
        chk({tag, ":p@1"}, cfg_offset_p, 0);
        chk({tag, ":n@1"}, cfg_offset_n, 0);
        chk({tag, ":sat@1"}, cal_sat, 0);
        while (done !== 1'b1 && n < 400) begin
            if (n == DEC_LEN + 1) begin
                chk({tag, ":side_p"}, cfg_offset_p, side_n ? 0 : 16);
                chk({tag, ":side_n"}, cfg_offset_n, side_n ? 16 : 0);
            end
            start  = (n == extra_start);
            glitch = (n == glitch_cyc);
            @(negedge clk);
            n++;
        end
        start  = 1'b0;
        glitch = 1'b0;
        chk({tag, ":done_cyc"}, n, DONE_CYC);
        chk({tag, ":p"}, cfg_offset_p, exp_p);
        chk({tag, ":n"}, cfg_offset_n, exp_n);
        chk({tag, ":sat"}, cal_sat, exp_sat);
        chk({tag, ":busy_fall"}, busy, 0);
        chk({tag, ":cal_en_fall"}, cal_en, 0);
        @(negedge clk);
        chk({tag, ":done_pulse"}, done, 0);
        chk({tag, ":p_held"}, cfg_offset_p, exp_p);
        chk({tag, ":sat_held"}, cal_sat, exp_sat);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst:p", cfg_offset_p, 0);
        chk("rst:n", cfg_offset_n, 0);
        chk("rst:busy", busy, 0);
        chk("rst:cal_en", cal_en, 0);
        chk("rst:done", done, 0);
        chk("rst:sat", cal_sat, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cal("neg7p4", -74, 1'b0, 7, 0, 0, -1, -1);
        run_cal("pos12p6", 126, 1'b1, 0, 12, 0, -1, -1);
        run_cal("zero", 0, 1'b1, 0, 0, 0, -1, -1);
        run_cal("neg40", -400, 1'b0, 31, 0, 1, -1, -1);
        repeat (5) @(negedge clk);
        chk("neg40:sat_hold", cal_sat, 1);
        chk("neg40:p_hold", cfg_offset_p, 31);
        run_cal("busy_start", -74, 1'b0, 7, 0, 0, 10, -1);

        // reset during the bit-2 settle window
        vos_t = -74;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3 * DEC_LEN + 1) @(negedge clk);
        chk("mid:pre_p", cfg_offset_p, 4);
        chk("mid:pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid:p", cfg_offset_p, 0);
        chk("mid:n", cfg_offset_n, 0);
        chk("mid:busy", busy, 0);
        chk("mid:cal_en", cal_en, 0);
        chk("mid:done", done, 0);
        chk("mid:sat", cal_sat, 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid:idle_busy", busy, 0);
        chk("mid:idle_p", cfg_offset_p, 0);

        run_cal("post_rst", -74, 1'b0, 7, 0, 0, -1, -1);
`ifdef COMP_CAL_VOTE_EN
        // inverts the second of the three samples of the bit-4 decision
        run_cal("vote_glitch", -74, 1'b0, 7, 0, 0, -1, 12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
